// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of the multiplexed seven-segment bus.
// Registers the scanned anode/segment pair and waits for each digit to
// settle. It then decodes the active-low pattern back to BCD and publishes
// MM:SS atomically, one complete frame at a time.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] anode,
  input  logic [6:0] segments,
  output logic [3:0] minutes_tens,
  output logic [3:0] minutes_units,
  output logic [3:0] seconds_tens,
  output logic [3:0] seconds_units,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       anode_err,
  output logic       stale
);
  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
  } pair_t;

  typedef enum logic [1:0] {SAMPLE, SETTLE, HOLD} state_t;

  localparam pair_t           BLANK    = '{anode: 4'hF, seg: 7'h7F};
  localparam logic [7:0]      SETTLE_N = 8'(SETTLE_CYCLES);
  localparam logic [TO_W-1:0] TO_N     = TO_W'(TIMEOUT_CYCLES);

  pair_t           cur, prev;
  logic            change;
  logic [7:0]      dwell, dwell_nx;
  logic            hit, cap;
  state_t          state, state_nx;
  logic [1:0]      sel_idx;
  logic            sel_ok, sel_blank;
  logic [3:0]      dec;
  logic            dec_ok;
  logic            cap_dig, cap_bad;
  logic [TO_W-1:0] to_cnt, to_nx;
  logic            to_hit;
  logic [3:0]      mask;
  logic [3:0][3:0] shadow, digits;

  // Input register plus a copy of the previous registered pair
  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= BLANK;
      prev <= BLANK;
    end else begin
      cur  <= '{anode: anode, seg: segments};
      prev <= cur;
    end
  end

  assign change = (cur != prev);

  // Dwell = cycles the current registered pair has been held, this one
  // included; it restarts at 1 on a change and saturates so it hits
  // SETTLE_CYCLES exactly once per dwell.
  always_comb begin
    dwell_nx = 8'd1;
    if (!change) dwell_nx = (dwell == 8'hFF) ? dwell : dwell + 8'd1;
  end

  assign hit = (dwell_nx == SETTLE_N);

  // Dwell counter register
  always_ff @(posedge clk) begin
    if (reset) dwell <= '0;
    else       dwell <= dwell_nx;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= SAMPLE;
    else       state <= state_nx;
  end

  // FSM next state: any change (re)starts settling, a settle hit parks in HOLD
  always_comb begin
    state_nx = state;
    unique case (state)
      SAMPLE:  if (change) state_nx = hit ? HOLD : SETTLE;
      SETTLE:  if (hit)    state_nx = HOLD;
      HOLD:    if (change) state_nx = hit ? HOLD : SETTLE;
      default: state_nx = SAMPLE;
    endcase
  end

  // FSM output: capture strobe, held off until a first change after reset
  always_comb begin
    cap = hit && ((state != SAMPLE) || change);
  end

  // Digit select and segment decode of the registered pair
  always_comb begin
    sel_idx   = 2'd0;
    sel_ok    = 1'b1;
    sel_blank = 1'b0;
    unique case (cur.anode)
      4'b0111: sel_idx = 2'd3;
      4'b1011: sel_idx = 2'd2;
      4'b1101: sel_idx = 2'd1;
      4'b1110: sel_idx = 2'd0;
      4'b1111: begin sel_ok = 1'b0; sel_blank = 1'b1; end
      default: sel_ok = 1'b0;
    endcase
    dec    = 4'hF;
    dec_ok = 1'b1;
    unique case (cur.seg)
      7'h40:   dec = 4'd0;
      7'h79:   dec = 4'd1;
      7'h24:   dec = 4'd2;
      7'h30:   dec = 4'd3;
      7'h19:   dec = 4'd4;
      7'h12:   dec = 4'd5;
      7'h02:   dec = 4'd6;
      7'h78:   dec = 4'd7;
      7'h00:   dec = 4'd8;
      7'h10:   dec = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  assign cap_dig = cap && sel_ok;
  assign cap_bad = cap && !sel_ok && !sel_blank;
  assign to_nx   = to_cnt + TO_W'(1);
  assign to_hit  = (to_nx == TO_N);

  // Frame assembly, error pulses and timeout; a digit capture beats timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      mask        <= '0;
      shadow      <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
      stale       <= 1'b1;
      to_cnt      <= '0;
    end else begin
      frame_valid <= 1'b0;
      seg_err     <= cap_dig && !dec_ok;
      anode_err   <= cap_bad;
      to_cnt      <= (cap_dig || to_hit) ? '0 : to_nx;
      if (mask == 4'hF) begin
        digits      <= shadow;
        frame_valid <= 1'b1;
        stale       <= 1'b0;
      end
      if (cap_bad) begin
        mask   <= '0;
        shadow <= '0;
      end else if (cap_dig) begin
        mask            <= ((mask == 4'hF) ? 4'h0 : mask) | (4'b0001 << sel_idx);
        shadow[sel_idx] <= dec;
      end else if (to_hit || mask == 4'hF) begin
        mask <= '0;
      end
      if (to_hit && !cap_dig) stale <= 1'b1;
    end
  end

  assign minutes_tens  = digits[3];
  assign minutes_units = digits[2];
  assign seconds_tens  = digits[1];
  assign seconds_units = digits[0];

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans plus random scanning, every cycle
// compared against a history-window reference model of the decoder.
module tb_seg_scan_decoder;
  localparam int S  = 4;
  localparam int TO = 4096;
  localparam logic [10:0] BLANK = 11'h7FF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] anode = 4'hF;
  logic [6:0] segments = 7'h7F;
  logic [3:0] minutes_tens, minutes_units, seconds_tens, seconds_units;
  logic       frame_valid, seg_err, anode_err, stale;

  int n_chk = 0, n_fail = 0;
  int fv_seen = 0, se_seen = 0, ae_seen = 0;

  // reference model state
  logic [6:0]  codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [10:0] hist [$];
  logic [3:0]  m_out [4];
  logic [3:0]  m_sh [4];
  logic [3:0]  m_mask;
  logic        m_fv, m_se, m_ae, m_stale;
  int          t = 0, last_base = 0;

  seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO), .TO_W(13)) dut (
    .clk(clk), .reset(reset), .anode(anode), .segments(segments),
    .minutes_tens(minutes_tens), .minutes_units(minutes_units),
    .seconds_tens(seconds_tens), .seconds_units(seconds_units),
    .frame_valid(frame_valid), .seg_err(seg_err), .anode_err(anode_err),
    .stale(stale)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input int d);
    return (d >= 0 && d < 10) ? codes[d] : 7'h7F;
  endfunction

  // digit position of the single low anode bit; -1 blank, -2 illegal
  function automatic int sel_pos(input logic [3:0] a);
    int z = 0, p = -1;
    for (int i = 0; i < 4; i++) if (!a[i]) begin z++; p = i; end
    if (z == 0) return -1;
    if (z == 1) return p;
    return -2;
  endfunction

  function automatic int decode(input logic [6:0] s);
    int v = 15;
    for (int i = 0; i < 10; i++) if (codes[i] == s) v = i;
    return v;
  endfunction

  // One clock edge of the model. A digit is taken when the last S
  // registered pairs agree and the one before them differs.
  task automatic model_edge(input bit rst, input logic [10:0] pin);
    bit          cap, dig;
    logic [10:0] v;
    logic [3:0]  nmask;
    int          pos, val;
    t++;
    m_fv = 0; m_se = 0; m_ae = 0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_out[i] = 0; m_sh[i] = 0; end
      m_mask = 0; m_stale = 1; last_base = t;
      hist.delete();
      repeat (S + 1) hist.push_back(BLANK);
    end else begin
      v = hist[S];
      cap = (hist[0] != v);
      for (int i = 1; i < S; i++) if (hist[i] != v) cap = 0;
      dig = 0;
      nmask = m_mask;
      if (m_mask == 4'hF) begin
        for (int i = 0; i < 4; i++) m_out[i] = m_sh[i];
        m_fv = 1; m_stale = 0; nmask = 0;
      end
      if (cap) begin
        pos = sel_pos(v[10:7]);
        if (pos >= 0) begin
          val = decode(v[6:0]);
          m_sh[pos] = 4'(val);
          nmask[pos] = 1'b1;
          m_se = (val == 15);
          dig = 1; last_base = t;
        end else if (pos == -2) begin
          m_ae = 1; nmask = 0;
          for (int i = 0; i < 4; i++) m_sh[i] = 0;
        end
      end
      if (!dig && (t - last_base) == TO) begin
        nmask = 0; m_stale = 1; last_base = t;
      end
      m_mask = nmask;
      hist.push_back(pin);
      void'(hist.pop_front());
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive one cycle, advance the model, compare all outputs after the edge
  task automatic step(input logic [3:0] a, input logic [6:0] s, input bit r);
    logic [19:0] obs, exp;
    @(negedge clk);
    anode = a; segments = s; reset = r;
    @(posedge clk);
    model_edge(r, {a, s});
    #1;
    obs = {minutes_tens, minutes_units, seconds_tens, seconds_units,
           frame_valid, seg_err, anode_err, stale};
    exp = {m_out[3], m_out[2], m_out[1], m_out[0], m_fv, m_se, m_ae, m_stale};
    fv_seen += int'(frame_valid);
    se_seen += int'(seg_err);
    ae_seen += int'(anode_err);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL outputs t=%0d observed=%h expected=%h", t, obs, exp);
    end
  endtask

  // scan digits in display order; n limits how many are shown
  task automatic scan(input int mt, input int mu, input int st, input int su,
                      input int dwell, input bit glitch, input int n);
    int         d [4];
    logic [3:0] a;
    logic [6:0] s;
    d[3] = mt; d[2] = mu; d[1] = st; d[0] = su;
    for (int k = 3; k >= 4 - n; k--) begin
      a = ~(4'b0001 << k);
      s = enc(d[k]);
      if (glitch) begin
        step(a, s ^ 7'h08, 1'b0);
        step(a, s ^ 7'h10, 1'b0);
      end
      repeat (dwell) step(a, s, 1'b0);
    end
  endtask

  task automatic clr_seen();
    fv_seen = 0; se_seen = 0; ae_seen = 0;
  endtask

  initial begin
    // reset state
    repeat (3) step(4'hF, 7'h7F, 1'b1);
    chk("reset_stale", {3'b0, stale}, 4'h1);
    chk("reset_mt", minutes_tens, 4'h0);
    repeat (4) step(4'hF, 7'h7F, 1'b0);

    // 12:34 scanned three times
    clr_seen();
    repeat (3) scan(1, 2, 3, 4, 8, 1'b0, 4);
    chk("scan_fv_count", 4'(fv_seen), 4'd3);
    chk("scan_mt", minutes_tens, 4'd1);
    chk("scan_mu", minutes_units, 4'd2);
    chk("scan_st", seconds_tens, 4'd3);
    chk("scan_su", seconds_units, 4'd4);
    chk("scan_stale", {3'b0, stale}, 4'h0);

    // glitchy dwell starts
    clr_seen();
    repeat (2) scan(5, 6, 0, 7, 8, 1'b1, 4);
    chk("glitch_fv_count", 4'(fv_seen), 4'd2);
    chk("glitch_mu", minutes_units, 4'd6);
    chk("glitch_su", seconds_units, 4'd7);

    // illegal segment pattern on minutes_units
    clr_seen();
    scan(2, 15, 4, 8, 8, 1'b0, 4);
    chk("segerr_count", 4'(se_seen), 4'd1);
    chk("segerr_mu", minutes_units, 4'hF);
    chk("segerr_fv", 4'(fv_seen), 4'd1);

    // illegal anode mid-frame, then a clean scan
    clr_seen();
    scan(3, 3, 0, 0, 8, 1'b0, 2);
    repeat (6) step(4'b0011, enc(5), 1'b0);
    scan(9, 8, 7, 6, 8, 1'b0, 4);
    chk("anerr_count", 4'(ae_seen), 4'd1);
    chk("anerr_fv", 4'(fv_seen), 4'd1);
    chk("anerr_mt", minutes_tens, 4'd9);

    // stop after two digits and let the timeout expire
    clr_seen();
    scan(1, 1, 0, 0, 8, 1'b0, 2);
    repeat (TO + 10) step(4'hF, 7'h7F, 1'b0);
    chk("to_stale", {3'b0, stale}, 4'h1);
    chk("to_fv", 4'(fv_seen), 4'd0);
    chk("to_mt", minutes_tens, 4'd9);
    chk("to_su", seconds_units, 4'd6);

    // reset mid-frame, then a fresh scan
    scan(4, 4, 4, 4, 8, 1'b0, 4);
    scan(2, 1, 0, 0, 8, 1'b0, 1);
    step(~4'b0100, enc(1), 1'b0);
    step(~4'b0100, enc(1), 1'b1);
    chk("rst_mt", minutes_tens, 4'd0);
    chk("rst_stale", {3'b0, stale}, 4'h1);
    clr_seen();
    scan(3, 4, 5, 6, 8, 1'b0, 4);
    chk("rst_fv", 4'(fv_seen), 4'd1);
    chk("rst_st", seconds_tens, 4'd5);

    // random scanning with odd anodes, bad segments and rare resets
    for (int n = 0; n < 300; n++) begin
      logic [3:0] a;
      logic [6:0] s;
      int         sel, dw;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       a = ~(4'b0001 << $urandom_range(0, 3));
      else if (sel < 8)  a = 4'hF;
      else               a = 4'($urandom);
      if ($urandom_range(0, 7) == 0) s = 7'($urandom);
      else                           s = codes[$urandom_range(0, 9)];
      dw = int'($urandom_range(1, 10));
      repeat (dw) step(a, s, $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive end of the multiplexed seven-segment display interface.
- Samples the scanned anode/segments bus, waits for each digit to settle, and decodes the segment pattern back to BCD.
- Reassembles the four digits (MM:SS) into one coherent frame.
- Used as an on-chip readback/self-check monitor beside the display controller, and as the bench's display scoreboard.

Parameters:
- SETTLE_CYCLES, 4, consecutive stable cycles required before a digit is captured (range 1..255).
- TIMEOUT_CYCLES, 4096, cycles without any capture before the partial frame is dropped and stale asserts.
- TO_W, 13, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- anode  in  4  active-low digit select; 4'b0111=minutes_tens, 1011=minutes_units, 1101=seconds_tens, 1110=seconds_units, 1111=blank
- segments  in  7  active-low segments; bit0=a … bit6=g
- minutes_tens  out  4  decoded digit of last complete frame
- minutes_units  out  4  decoded digit
- seconds_tens  out  4  decoded digit
- seconds_units  out  4  decoded digit
- frame_valid  out  1  one-cycle pulse when all four outputs update
- seg_err  out  1  one-cycle pulse: captured pattern is not a legal digit
- anode_err  out  1  one-cycle pulse: anode is neither one-hot-low nor 4'b1111
- stale  out  1  no complete frame since reset or since last timeout

Behaviour:
- Reset (synchronous, active-high):
  - Digit outputs 0, frame_valid/seg_err/anode_err 0, stale 1.
  - Capture mask, shadow digits, dwell and timeout counters all cleared.
  - Reset mid-frame discards all partial data.
- Input stage: anode and segments are registered once. All further logic uses the registered pair.
- Dwell tracking:
  - The dwell counter clears whenever the registered pair differs from the previous registered pair; otherwise it increments, saturating.
  - A digit captures exactly once per dwell, on the cycle the counter reaches SETTLE_CYCLES.
  - Required latency: capture happens SETTLE_CYCLES+1 clock edges after a stable pair first appears at the pins.
- FSM (SAMPLE, SETTLE, HOLD):
  - SAMPLE: wait for a change of the pair, then go to SETTLE.
  - SETTLE: count the dwell. On reaching SETTLE_CYCLES, capture and go to HOLD. Any change restarts SETTLE.
  - HOLD: wait for a change of the pair, then go to SETTLE.
  - Blank (4'b1111) dwells never capture and do not set any error.
- Decode (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any other pattern: pulse seg_err, write 4'hF to the shadow digit, and still set the mask bit (the frame completes carrying 4'hF).
- Illegal anode (more than one low bit, or a zero-hot pattern other than 1111):
  - On the capture cycle only, pulse anode_err and clear the mask and shadows.
  - The FSM goes to HOLD.
- Frame assembly:
  - Each capture writes its shadow digit and sets its mask bit.
  - Recapture of a digit already in the mask overwrites the shadow (latest wins).
  - The cycle after the mask becomes 4'b1111:
    - All four outputs load the shadows atomically.
    - frame_valid pulses for one cycle and stale clears.
    - The mask clears.
  - Outputs hold between frames.
- Timeout:
  - The counter resets on every capture and otherwise increments.
  - On reaching TIMEOUT_CYCLES: clear the mask, set stale, and restart counting. Outputs keep their last values.
- Simultaneous events:
  - Timeout and capture on the same cycle: the capture wins and the counter resets.
  - Reset dominates everything.

Test Plan:
- Scan 12:34 repeatedly (anode 0111/seg 79, 1011/24, 1101/30, 1110/19; dwell 8 cycles each, SETTLE_CYCLES=4) -> frame_valid pulses once per full scan; outputs 1,2,3,4; stale falls on the first pulse.
- Glitch: toggle segments for 2 cycles at the start of each dwell -> no capture until 5 edges after the final change; decoded values are still correct.
- Illegal pattern seg=7'h7F on minutes_units -> seg_err pulses once; frame completes with minutes_units=4'hF.
- anode=4'b0011 held 6 cycles mid-frame -> anode_err pulses once; partial frame discarded; the next clean full scan yields frame_valid.
- Stop scanning after 2 digits (anode=1111) for TIMEOUT_CYCLES -> stale=1; outputs keep the previous frame; no frame_valid.
- Assert reset mid-frame for 1 cycle -> all outputs 0, stale=1; the first frame_valid comes only after four fresh captures.
